// File: rtl/bus_pkg.sv
// Shared definitions for the DMAC-side memory responder.
//   - Bus address/data widths and the matching typedefs.
//   - Arbiter FSM state encoding (kept as plain 2-bit constants).
//   - Width of the grant-delay counter.
//   - addr_in_range(): word-address check against a memory depth.
package bus_pkg;

    localparam int BUS_AW = 8;
    localparam int BUS_DW = 32;
    localparam int CNT_W  = 4;

    typedef logic [BUS_AW-1:0] bus_addr_t;
    typedef logic [BUS_DW-1:0] bus_data_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_GRANT = 2'd2;

    // True when addr names a word that physically exists in a memory of
    // 'depth' words. Addresses at or above depth must neither alias into
    // the array nor be written.
    function automatic logic addr_in_range(input bus_addr_t addr, input int depth);
        return (int'(addr) < depth);
    endfunction

endpackage

// File: rtl/bus_mem_responder_if.sv
// Bus bundle between the DMAC master port and the memory responder.
//   M_req/M_wr/M_address/M_dout : request, direction, address, write data (from DMAC)
//   M_grant/M_din               : grant and read data (to DMAC)
//   H_wr/H_address/H_din        : host backdoor write strobe, address, data
//   H_dout/H_busy               : host read data, bus-granted indication
// Modports: slave = responder side, master = DMAC/host side.
interface bus_mem_responder_if;
    import bus_pkg::*;

    logic      M_req;
    logic      M_wr;
    bus_addr_t M_address;
    bus_data_t M_dout;
    logic      M_grant;
    bus_data_t M_din;

    logic      H_wr;
    bus_addr_t H_address;
    bus_data_t H_din;
    bus_data_t H_dout;
    logic      H_busy;

    modport slave (
        input  M_req, M_wr, M_address, M_dout, H_wr, H_address, H_din,
        output M_grant, M_din, H_dout, H_busy
    );

    modport master (
        output M_req, M_wr, M_address, M_dout, H_wr, H_address, H_din,
        input  M_grant, M_din, H_dout, H_busy
    );

endinterface

// File: rtl/bus_mem_array.sv
// DEPTH x 32 word memory: one write port, two registered read ports.
//   Clk, reset_n : clock, asynchronous active-low reset (read registers only;
//                  the storage itself is never cleared)
//   wr_en/wr_addr/wr_data : write port; out-of-range addresses are ignored
//   rd_en[i]/rd_addr[i]   : read port i; rd_data[i] updates only when enabled
//   rd_data[i]            : registered read data, 0 for out-of-range reads
// Reads sample the array before the same-edge write lands, so a read and a
// write to one address on the same edge returns the old contents.
module bus_mem_array
    import bus_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                   Clk,
    input  logic                   reset_n,
    input  logic                   wr_en,
    input  bus_addr_t              wr_addr,
    input  bus_data_t              wr_data,
    input  logic [1:0]             rd_en,
    input  logic [1:0][BUS_AW-1:0] rd_addr,
    output logic [1:0][BUS_DW-1:0] rd_data
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    bus_data_t mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (wr_en && addr_in_range(wr_addr, DEPTH)) begin
            mem[wr_addr[IDX_W-1:0]] <= wr_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            bus_data_t rd_data_reg;

            always_ff @(posedge Clk or negedge reset_n) begin
                if (!reset_n) begin
                    rd_data_reg <= '0;
                end else if (rd_en[gi]) begin
                    rd_data_reg <= addr_in_range(rd_addr[gi], DEPTH)
                                   ? mem[rd_addr[gi][IDX_W-1:0]] : '0;
                end
            end

            assign rd_data[gi] = rd_data_reg;
        end
    endgenerate

endmodule

// File: rtl/bus_mem_responder.sv
// Memory responder for the DMAC master port.
//   Clk     : clock, all state changes on the rising edge
//   reset_n : asynchronous active-low reset
//   mbus    : bus_mem_responder_if.slave (M_* DMAC bus, H_* host backdoor)
// Parameters: DEPTH (words, power of two, <= 256), GRANT_DELAY (0..15 extra
// cycles between request and grant).
// The arbiter grants after GRANT_DELAY wait cycles and holds the grant while
// M_req stays high. While granted, each edge with M_req high is one master
// access. The host port reads every edge and writes only when not granted.
module bus_mem_responder
    import bus_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int GRANT_DELAY = 2
) (
    input  logic                 Clk,
    input  logic                 reset_n,
    bus_mem_responder_if.slave   mbus
);

    localparam logic [CNT_W-1:0] CNT_LOAD =
        (GRANT_DELAY > 0) ? CNT_W'(GRANT_DELAY - 1) : '0;

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             grant_reg;

    logic             m_active;
    logic             m_we;
    logic             h_we;
    logic             wr_en;
    bus_addr_t        wr_addr;
    bus_data_t        wr_data;
    logic [1:0][BUS_DW-1:0] rd_data;

    // Arbiter: the counter is loaded on leaving IDLE and counts down in WAIT;
    // a withdrawn request always returns to IDLE so a re-request restarts
    // the full delay.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (mbus.M_req) begin
                    if (GRANT_DELAY == 0) begin
                        state_next = ST_GRANT;
                    end else begin
                        state_next = ST_WAIT;
                        cnt_next   = CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (!mbus.M_req) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == '0) begin
                    state_next = ST_GRANT;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            ST_GRANT: begin
                if (!mbus.M_req) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            grant_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            // Registered copy of (state == GRANT) so the grant output has
            // no decode logic after the flop.
            grant_reg <= (state_next == ST_GRANT);
        end
    end

    // Master and host writes are mutually exclusive by state, so the mux
    // select only needs the master term. Writes are also blocked while
    // reset is held so nothing in flight lands during a reset pulse.
    assign m_active = (state_reg == ST_GRANT) && mbus.M_req;
    assign m_we     = m_active && mbus.M_wr;
    assign h_we     = mbus.H_wr && (state_reg != ST_GRANT);
    assign wr_en    = reset_n && (m_we || h_we);
    assign wr_addr  = m_we ? mbus.M_address : mbus.H_address;
    assign wr_data  = m_we ? mbus.M_dout    : mbus.H_din;

    bus_mem_array #(
        .DEPTH (DEPTH)
    ) u_mem (
        .Clk     (Clk),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   ({1'b1, m_active && !mbus.M_wr}),
        .rd_addr ({mbus.H_address, mbus.M_address}),
        .rd_data (rd_data)
    );

    assign mbus.M_grant = grant_reg;
    assign mbus.H_busy  = grant_reg;
    assign mbus.M_din   = rd_data[0];
    assign mbus.H_dout  = rd_data[1];

endmodule

// File: tb/tb_bus_mem_responder.sv
// Self-checking bench for bus_mem_responder.
// Main DUT: DEPTH=128 (so out-of-range addresses exist), GRANT_DELAY=2.
// Second DUT: GRANT_DELAY=0 for the zero-latency grant.
module tb_bus_mem_responder;
    import bus_pkg::*;

    localparam int DEPTH0 = 128;

    logic Clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 Clk = ~Clk;

    bus_mem_responder_if bif ();
    bus_mem_responder_if bif_z ();

    bus_mem_responder #(.DEPTH(DEPTH0), .GRANT_DELAY(2)) dut (
        .Clk     (Clk),
        .reset_n (reset_n),
        .mbus    (bif)
    );

    bus_mem_responder #(.DEPTH(256), .GRANT_DELAY(0)) dut_z (
        .Clk     (Clk),
        .reset_n (reset_n),
        .mbus    (bif_z)
    );

    typedef struct {
        logic      m_req;
        logic      m_wr;
        bus_addr_t m_addr;
        bus_data_t m_dout;
        logic      h_wr;
        bus_addr_t h_addr;
        bus_data_t h_din;
        logic      exp_grant;
    } vec_t;

    vec_t      vecs [$];
    bus_data_t m_q [$];
    bus_data_t h_q [$];
    bus_data_t model [256];
    bus_data_t exp_mdin;

    int checks = 0;
    int errors = 0;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic w, input int ma, input logic [31:0] md,
                                input logic hw, input int ha, input logic [31:0] hd, input logic g);
        vec_t v;
        v.m_req     = r;
        v.m_wr      = w;
        v.m_addr    = 8'(ma);
        v.m_dout    = md;
        v.h_wr      = hw;
        v.h_addr    = 8'(ha);
        v.h_din     = hd;
        v.exp_grant = g;
        return v;
    endfunction

    function automatic bus_data_t model_rd(input bus_addr_t a);
        return (int'(a) < DEPTH0) ? model[a] : '0;
    endfunction

    task automatic drive_idle();
        bif.M_req = 0; bif.M_wr = 0; bif.M_address = '0; bif.M_dout = '0;
        bif.H_wr = 0; bif.H_address = '0; bif.H_din = '0;
        bif_z.M_req = 0; bif_z.M_wr = 0; bif_z.M_address = '0; bif_z.M_dout = '0;
        bif_z.H_wr = 0; bif_z.H_address = '0; bif_z.H_din = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic prev_g;
        logic active;
        vec_t v;

        drive_idle();
        reset_n = 0;
        repeat (3) tick();
        chk("rst_grant", 32'(bif.M_grant), 32'd0);
        chk("rst_busy", 32'(bif.H_busy), 32'd0);
        chk("rst_mdin", bif.M_din, 32'd0);
        chk("rst_hdout", bif.H_dout, 32'd0);
        chk("rst_grant_z", 32'(bif_z.M_grant), 32'd0);

        // Grant latency with GRANT_DELAY=2: request first sampled at edge k.
        reset_n = 1;
        tick();
        bif.M_req = 1;
        tick(); chk("lat_k_grant", 32'(bif.M_grant), 32'd0); chk("lat_k_mdin", bif.M_din, 32'd0);
        tick(); chk("lat_k1_grant", 32'(bif.M_grant), 32'd0); chk("lat_k1_mdin", bif.M_din, 32'd0);
        tick(); chk("lat_k2_grant", 32'(bif.M_grant), 32'd1); chk("lat_k2_busy", 32'(bif.H_busy), 32'd1);
        chk("lat_k2_mdin", bif.M_din, 32'd0);
        bif.M_req = 0;
        tick(); chk("lat_rel_grant", 32'(bif.M_grant), 32'd0); chk("lat_rel_mdin", bif.M_din, 32'd0);

        // GRANT_DELAY=0: grant one edge after the request.
        bif_z.M_req = 1;
        tick(); chk("z_grant_on", 32'(bif_z.M_grant), 32'd1);
        bif_z.M_req = 0;
        tick(); chk("z_grant_off", 32'(bif_z.M_grant), 32'd0);
        $display("seq: grant latency done");

        // Give every word a known value through the host port.
        for (int a = 0; a < 256; a++) begin
            bif.H_wr = 1;
            bif.H_address = 8'(a);
            bif.H_din = 32'hA5A5_0000 | 32'(a);
            if (a < DEPTH0) model[a] = 32'hA5A5_0000 | 32'(a);
            tick();
        end
        bif.H_wr = 0;
        $display("seq: memory initialised");

        // r  w  maddr mdout     hw hadr hdin        grant
        vecs.push_back(mk(0, 0, 0,   0,           1, 10,  100,          0));
        vecs.push_back(mk(0, 0, 0,   0,           1, 11,  200,          0));
        vecs.push_back(mk(0, 0, 0,   0,           1, 12,  300,          0));
        vecs.push_back(mk(0, 0, 0,   0,           1, 13,  400,          0));
        vecs.push_back(mk(0, 0, 0,   0,           1, 5,   32'h555,      0));
        vecs.push_back(mk(1, 0, 0,   0,           0, 10,  0,            0));
        vecs.push_back(mk(1, 0, 0,   0,           0, 11,  0,            0));
        vecs.push_back(mk(1, 0, 10,  0,           0, 12,  0,            1));
        vecs.push_back(mk(1, 0, 10,  0,           0, 10,  0,            1));
        vecs.push_back(mk(1, 0, 11,  0,           0, 0,   0,            1));
        vecs.push_back(mk(1, 0, 12,  0,           0, 0,   0,            1));
        vecs.push_back(mk(1, 0, 13,  0,           0, 0,   0,            1));
        vecs.push_back(mk(1, 1, 20,  1,           0, 0,   0,            1));
        vecs.push_back(mk(1, 1, 21,  2,           0, 0,   0,            1));
        vecs.push_back(mk(1, 1, 22,  3,           0, 0,   0,            1));
        vecs.push_back(mk(1, 1, 23,  4,           0, 0,   0,            1));
        vecs.push_back(mk(1, 0, 20,  0,           1, 5,   32'hDEAD,     1));
        vecs.push_back(mk(1, 1, 200, 32'hBAD,     0, 200, 0,            1));
        vecs.push_back(mk(1, 0, 200, 0,           0, 0,   0,            1));
        vecs.push_back(mk(1, 1, 13,  32'h1313,    0, 13,  0,            1));
        vecs.push_back(mk(0, 1, 13,  32'hFFFF,    0, 13,  0,            0));
        vecs.push_back(mk(0, 0, 0,   0,           1, 5,   32'hDEAD,     0));
        vecs.push_back(mk(0, 0, 0,   0,           0, 5,   0,            0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 20 + i, 0, 0));
        vecs.push_back(mk(0, 0, 0,   0,           0, 200, 0,            0));
        vecs.push_back(mk(0, 0, 0,   0,           0, 72,  0,            0));
        // one-cycle pulse, then a fresh request needing the full wait
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        // drop and immediately re-raise restarts the wait
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));

        exp_mdin = '0;
        prev_g = 1'b0;
        foreach (vecs[i]) begin
            v = vecs[i];
            bif.M_req = v.m_req; bif.M_wr = v.m_wr; bif.M_address = v.m_addr; bif.M_dout = v.m_dout;
            bif.H_wr = v.h_wr; bif.H_address = v.h_addr; bif.H_din = v.h_din;

            // Expected reads use memory contents before this edge's write.
            active = prev_g && v.m_req;
            if (active && !v.m_wr) m_q.push_back(model_rd(v.m_addr));
            h_q.push_back(model_rd(v.h_addr));
            if (active && v.m_wr && int'(v.m_addr) < DEPTH0) model[v.m_addr] = v.m_dout;
            if (v.h_wr && !prev_g && int'(v.h_addr) < DEPTH0) model[v.h_addr] = v.h_din;

            tick();

            chk($sformatf("v%0d_grant", i), 32'(bif.M_grant), 32'(v.exp_grant));
            chk($sformatf("v%0d_busy", i), 32'(bif.H_busy), 32'(v.exp_grant));
            if (active && !v.m_wr && m_q.size() > 0) exp_mdin = m_q.pop_front();
            chk($sformatf("v%0d_mdin", i), bif.M_din, exp_mdin);
            if (h_q.size() > 0) chk($sformatf("v%0d_hdout", i), bif.H_dout, h_q.pop_front());
            $display("vec %0d: req=%b wr=%b maddr=%0d hwr=%b haddr=%0d grant=%b mdin=%h hdout=%h",
                     i, v.m_req, v.m_wr, v.m_addr, v.h_wr, v.h_addr, bif.M_grant, bif.M_din, bif.H_dout);
            prev_g = v.exp_grant;
        end
        chk("m_q_drained", 32'(m_q.size()), 32'd0);

        // Reset pulled low mid-grant during a write to address 30.
        bif.M_req = 1; bif.M_wr = 0; bif.H_wr = 0; bif.H_address = 8'd30;
        repeat (3) tick();
        chk("mid_pre_grant", 32'(bif.M_grant), 32'd1);
        bif.M_wr = 1; bif.M_address = 8'd30; bif.M_dout = 32'hBEEF_0030;
        #2 reset_n = 0;
        #1;
        chk("mid_async_grant", 32'(bif.M_grant), 32'd0);
        chk("mid_async_busy", 32'(bif.H_busy), 32'd0);
        chk("mid_async_mdin", bif.M_din, 32'd0);
        chk("mid_async_hdout", bif.H_dout, 32'd0);
        tick();
        bif.M_req = 0; bif.M_wr = 0;
        reset_n = 1;
        tick();
        chk("mid_post_grant", 32'(bif.M_grant), 32'd0);
        chk("mid_mem30", bif.H_dout, model_rd(8'd30));
        // A fresh request needs the full delay, so the FSM restarted in IDLE.
        bif.M_req = 1;
        tick(); chk("mid_idle_k", 32'(bif.M_grant), 32'd0);
        tick(); chk("mid_idle_k1", 32'(bif.M_grant), 32'd0);
        tick(); chk("mid_idle_k2", 32'(bif.M_grant), 32'd1);
        bif.M_req = 0;
        tick(); chk("mid_idle_rel", 32'(bif.M_grant), 32'd0);
        $display("seq: mid-grant reset done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
